// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// if_prefetch : instruction fetch unit feeding a DEPTH-entry prefetch queue
// Rev 1.0
// ============================================================================
module if_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0080
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       hold_if,
  input  logic                       br,
  input  logic [31:0]                pc_branch,
  input  logic                       except,
  output logic                       inst_valid,
  output logic [31:0]                pc_out,
  output logic [31:0]                inst_out,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [0:0] {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [PW-1:0] head, tail, head_nxt;
  logic [CW-1:0] count;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic          redirect, push, pop;

  assign redirect   = br | except;
  assign imem_req   = (state == RUN) && (count < FULL) && !redirect;
  assign imem_addr  = fpc;
  assign push       = imem_req && imem_ack;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && !hold_if && !redirect;
  assign head_nxt   = pop ? head + PW'(1) : head;
  assign q_count    = count;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= fpc;
      inst_mem[tail] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      fpc      <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pc_out   <= '0;
      inst_out <= '0;
    end else begin
      if (state == BOOT) state <= RUN;

      if (redirect) begin
        fpc   <= except ? EXC_VECTOR : {pc_branch[31:2], 2'b00};
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          fpc  <= fpc + 32'd4;
          tail <= tail + PW'(1);
        end
        head <= head_nxt;
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        // The entry being written this cycle becomes the head when the queue
        // is empty, or when its only entry is popped alongside the push.
        if (push && (head_nxt == tail)) begin
          pc_out   <= fpc;
          inst_out <= imem_rdata;
        end else begin
          pc_out   <= pc_mem[head_nxt];
          inst_out <= inst_mem[head_nxt];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// tb_if_prefetch : directed self-checking bench for if_prefetch
// Rev 1.0
// ============================================================================
module tb_if_prefetch;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        hold_if;
  logic        br;
  logic [31:0] pc_branch;
  logic        except;
  logic        inst_valid;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;

  if_prefetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .hold_if(hold_if), .br(br), .pc_branch(pc_branch), .except(except),
    .inst_valid(inst_valid), .pc_out(pc_out), .inst_out(inst_out),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Memory returns a word derived from the address so data can be predicted.
  assign imem_rdata = imem_addr ^ KEY;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT just out of reset, i.e. in its BOOT cycle.
  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b1; hold_if = 1'b0;
    br = 1'b0; except = 1'b0; pc_branch = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b1; hold_if = 1'b0;
    br = 1'b0; except = 1'b0; pc_branch = '0;
    @(posedge clk); #2;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || q_count !== 3'd0 ||
        pc_out !== 32'd0 || inst_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b req=%b cnt=%0d pc=%h inst=%h, want 0s",
               inst_valid, imem_req, q_count, pc_out, inst_out);
    end
  endtask

  task automatic test_stream();
    do_reset();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL boot_req: req=%b want 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      errors++; $display("FAIL first_fetch: req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || pc_out !== 32'(i * 4) ||
          inst_out !== (32'(i * 4) ^ KEY) || imem_addr !== 32'(i * 4 + 4) ||
          q_count !== 3'd1) begin
        errors++;
        $display("FAIL stream_%0d: v=%b pc=%h inst=%h addr=%h cnt=%0d want pc=%h",
                 i, inst_valid, pc_out, inst_out, imem_addr, q_count, 32'(i * 4));
      end
    end
  endtask

  task automatic test_hold_fill();
    do_reset();
    hold_if = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (q_count !== 3'(i) || pc_out !== 32'd0) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d pc=%h want cnt=%0d pc=0", i, q_count, pc_out, i);
      end
    end
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd16) begin
      errors++; $display("FAIL full_gate: req=%b addr=%h want 0/16", imem_req, imem_addr);
    end
    hold_if = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL full_pop_no_push: req=%b want 0", imem_req);
    end
    step();
    checks++;
    if (q_count !== 3'd3 || pc_out !== 32'd4 || imem_req !== 1'b1 || imem_addr !== 32'd16) begin
      errors++;
      $display("FAIL pop_from_full: cnt=%0d pc=%h req=%b addr=%h want 3/4/1/16",
               q_count, pc_out, imem_req, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q_count !== 3'd3 || pc_out !== 32'(8 + 4 * i) || inst_out !== (32'(8 + 4 * i) ^ KEY)) begin
        errors++;
        $display("FAIL refill_%0d: cnt=%0d pc=%h inst=%h want 3/%h",
                 i, q_count, pc_out, inst_out, 32'(8 + 4 * i));
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    hold_if = 1'b1;
    step();
    step(); step(); step();
    checks++;
    if (q_count !== 3'd3) begin
      errors++; $display("FAIL br_prefill: cnt=%0d want 3", q_count);
    end
    br = 1'b1; pc_branch = 32'h0000_0103;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL br_req_block: req=%b want 0", imem_req);
    end
    step();
    br = 1'b0;
    #1;
    checks++;
    if (q_count !== 3'd0 || inst_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL br_flush: cnt=%0d v=%b addr=%h req=%b want 0/0/100/1",
               q_count, inst_valid, imem_addr, imem_req);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h100 || inst_out !== (32'h100 ^ KEY)) begin
      errors++;
      $display("FAIL br_target: v=%b pc=%h inst=%h want 1/100", inst_valid, pc_out, inst_out);
    end
    br = 1'b1; pc_branch = 32'hFFFF_FFFF;
    step();
    br = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL br_lowbits: addr=%h want fffffffc", imem_addr);
    end
    step();
    checks++;
    if (imem_addr !== 32'd0 || pc_out !== 32'hFFFF_FFFC || q_count !== 3'd1) begin
      errors++;
      $display("FAIL fpc_wrap: addr=%h pc=%h cnt=%0d want 0/fffffffc/1", imem_addr, pc_out, q_count);
    end
    hold_if = 1'b0;
  endtask

  task automatic test_except();
    do_reset();
    step();
    step(); step();
    except = 1'b1; br = 1'b1; pc_branch = 32'h0000_0200;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL exc_req_block: req=%b want 0", imem_req);
    end
    step();
    except = 1'b0; br = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h8000_0080 || q_count !== 3'd0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL exc_prio: addr=%h cnt=%0d req=%b want 80000080/0/1", imem_addr, q_count, imem_req);
    end
    step();
    checks++;
    if (pc_out !== 32'h8000_0080 || inst_valid !== 1'b1 || imem_addr !== 32'h8000_0084) begin
      errors++;
      $display("FAIL exc_target: pc=%h v=%b addr=%h want 80000080/1/80000084",
               pc_out, inst_valid, imem_addr);
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    hold_if = 1'b1;
    step();
    step(); step();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_addr !== 32'd8 || imem_req !== 1'b1 || q_count !== 3'd2) begin
        errors++;
        $display("FAIL stall_%0d: addr=%h req=%b cnt=%0d want 8/1/2", i, imem_addr, imem_req, q_count);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q_count !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0 ||
        pc_out !== 32'd0 || inst_out !== 32'd0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d v=%b req=%b pc=%h inst=%h addr=%h want all 0",
               q_count, inst_valid, imem_req, pc_out, inst_out, imem_addr);
    end
    hold_if = 1'b0; imem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_boot: req=%b want 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      errors++; $display("FAIL restart: req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    step();
    checks++;
    if (pc_out !== 32'd0 || inst_valid !== 1'b1 || inst_out !== KEY) begin
      errors++; $display("FAIL restart_data: pc=%h v=%b inst=%h want 0/1/%h", pc_out, inst_valid, inst_out, KEY);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold_fill();
    test_branch();
    test_except();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
